// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RV32 encodings used by the EX-stage multiply/divide unit.
// Rev    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Values match the funct3 field of the M-extension instructions.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit_if
// Brief  : EX-stage operand / result bundle between pipeline and mul/div unit.
// Rev    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] instr_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic            is_muldiv_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output flush, instr_ex, rs1_data_ex, rs2_data_ex,
        input  is_muldiv_o, stall_o, done_o, result_o
    );

    modport slave (
        input  flush, instr_ex, rs1_data_ex, rs2_data_ex,
        output is_muldiv_o, stall_o, done_o, result_o
    );
endinterface : ex_muldiv_unit_if
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_unit
// Brief  : Iterative RV32M multiply/divide, one bit per cycle, stalls upstream.
// Rev    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);
    import riscv_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int              CNT_W  = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ONES = '1;

    function automatic logic [XLEN-1:0] f_neg_w(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg_p(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_e            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    muldiv_op_e        r_op;
    logic              r_neg_a, r_neg_b;
    logic [XLEN:0]     r_hi;
    logic [XLEN-1:0]   r_lo, r_b, r_result;
    logic              r_done;

    muldiv_op_e        w_op;
    logic              w_is_md, w_stall, w_last;
    logic              w_neg_a, w_neg_b, w_div0, w_ovf, w_special;
    logic [XLEN-1:0]   w_a, w_b, w_special_res;
    logic [XLEN:0]     w_sum, w_shift, w_hi_nx;
    logic [XLEN+1:0]   w_diff;
    logic [XLEN-1:0]   w_lo_nx, w_quo, w_rem, w_final;
    logic [2*XLEN-1:0] w_prod;
    logic              w_unused;

    // ---------------- decode ----------------
    assign w_op    = muldiv_op_e'(bus.instr_ex[14:12]);
    assign w_a     = bus.rs1_data_ex;
    assign w_b     = bus.rs2_data_ex;
    assign w_is_md = (bus.instr_ex[6:0] == OPC_OP) && (bus.instr_ex[31:25] == F7_MULDIV);
    assign w_neg_a = w_a[XLEN-1] && (w_op inside {MULH, MULHSU, DIV, REM});
    assign w_neg_b = w_b[XLEN-1] && (w_op inside {MULH, DIV, REM});
    assign w_div0  = bus.instr_ex[14] && (w_b == '0);
    assign w_ovf   = (w_op inside {DIV, REM}) && (w_a == C_MIN) && (w_b == C_ONES);
    assign w_special = w_div0 || w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign w_special_res = w_div0 ? (bus.instr_ex[13] ? w_a : C_ONES)
                                  : (bus.instr_ex[13] ? '0  : C_MIN);
    assign w_last  = (r_cnt == CNT_W'(XLEN-1));
    assign w_unused = ^{bus.instr_ex[24:15], bus.instr_ex[11:7], r_hi[XLEN]};

    // ---------------- one datapath step ----------------
    assign w_sum   = {1'b0, r_hi[XLEN-1:0]} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};

    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        if (r_op inside {DIV, DIVU, REM, REMU}) begin
            if (!w_diff[XLEN+1]) begin
                w_hi_nx = w_diff[XLEN:0];
                w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_nx = w_shift;
                w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // {hi,lo} shifts right with the carry out of the partial sum.
            w_hi_nx = {1'b0, w_sum[XLEN:1]};
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod = f_neg_p({w_hi_nx[XLEN-1:0], w_lo_nx}, r_neg_a ^ r_neg_b);
    assign w_quo  = f_neg_w(w_lo_nx, r_neg_a ^ r_neg_b);
    assign w_rem  = f_neg_w(w_hi_nx[XLEN-1:0], r_neg_a);

    always_comb begin
        w_final = w_rem;
        case (r_op)
            MUL:                  w_final = w_prod[XLEN-1:0];
            MULH, MULHSU, MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
            DIV, DIVU:            w_final = w_quo;
            default:              w_final = w_rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: if (w_is_md && !bus.flush) begin
                w_stall = 1'b1;
                w_next  = w_special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                w_stall = !bus.flush;
                if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.flush) w_next = S_IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= MUL;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (bus.flush) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_is_md) begin
                    r_op    <= w_op;
                    r_neg_a <= w_neg_a;
                    r_neg_b <= w_neg_b;
                    r_cnt   <= '0;
                    r_hi    <= '0;
                    // Multiplier (rs2) or dividend (rs1) is shifted out of lo; b is the other operand.
                    r_lo    <= bus.instr_ex[14] ? f_neg_w(w_a, w_neg_a) : f_neg_w(w_b, w_neg_b);
                    r_b     <= bus.instr_ex[14] ? f_neg_w(w_b, w_neg_b) : f_neg_w(w_a, w_neg_a);
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_done   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.is_muldiv_o = w_is_md;
    assign bus.stall_o     = w_stall;
    assign bus.done_o      = r_done;
    assign bus.result_o    = r_result;

endmodule : ex_muldiv_unit
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_muldiv_unit
// Brief  : Self-checking bench for ex_muldiv_unit with an arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    import riscv_pkg::*;

    localparam logic [31:0] C_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();
    ex_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_stall, exp_done;
    logic [31:0] exp_result;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic model_is_md(input logic [31:0] instr);
        return (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
    endfunction

    // Specification-level arithmetic: products in 64 bits, divides with SV operators.
    function automatic logic [31:0] model(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p_ss, p_su, p_uu;
        int sa, sb;
        sa   = a;
        sb   = b;
        p_ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        p_su = {{32{a[31]}}, a} * {32'b0, b};
        p_uu = {32'b0, a} * {32'b0, b};
        case (instr[14:12])
            3'd0: return p_uu[31:0];
            3'd1: return p_ss[63:32];
            3'd2: return p_su[63:32];
            3'd3: return p_uu[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == C_MIN && b == '1) ? C_MIN : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (a == C_MIN && b == '1) ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        if (instr[14] && b == 0) return 1;
        if ((instr[14:12] == 3'd4 || instr[14:12] == 3'd6) && a == C_MIN && b == '1) return 1;
        return 33;
    endfunction

    // Single compare process: every cycle, all outputs against the model expectation.
    always @(negedge clk) begin
        check("is_muldiv", 32'(bus.is_muldiv_o), 32'(model_is_md(bus.instr_ex) && !rst ? 1'b1 : model_is_md(bus.instr_ex)));
        check("stall",     32'(bus.stall_o),     32'(exp_stall));
        check("done",      32'(bus.done_o),      32'(exp_done));
        check("result",    bus.result_o,         exp_result);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_instr(input logic [31:0] instr, input int n);
        bus.instr_ex = instr;
        bus.flush    = 1'b0;
        exp_stall    = 1'b0;
        exp_done     = 1'b0;
        repeat (n) step();
    endtask

    // Holds the instruction in EX for its whole occupancy, as the stalled ID/EX would.
    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
        logic [31:0] instr, m;
        int lat;
        instr = mk(f3, 7'b0000001);
        m     = model(instr, a, b);
        lat   = model_lat(instr, a, b);
        check({name, "_model"}, m, lit);
        bus.instr_ex    = instr;
        bus.rs1_data_ex = a;
        bus.rs2_data_ex = b;
        bus.flush       = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            exp_stall = (k < lat);
            exp_done  = (k == lat);
            if (k == lat) exp_result = m;
            @(negedge clk);
            if (k == lat) check(name, bus.result_o, lit);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.instr_ex    = NOP_INSTR;
        bus.rs1_data_ex = '0;
        bus.rs2_data_ex = '0;
        exp_stall       = 1'b0;
        exp_done        = 1'b0;
        exp_result      = '0;
        repeat (2) step();
        check("reset_result", bus.result_o, 32'h0);
        check("reset_done",   32'(bus.done_o), 32'h0);
        rst = 1'b0;
        idle_instr(NOP_INSTR, 2);

        issue("mul_7_m3",  3'(MUL),    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        idle_instr(NOP_INSTR, 1);
        issue("mulhu_m1",  3'(MULHU),  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue("mulh_m1",   3'(MULH),   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        issue("mulhsu_m1", 3'(MULHSU), 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue("mul_m1",    3'(MUL),    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001);
        issue("mulh_min",  3'(MULH),   C_MIN,          C_MIN,         32'h4000_0000);
        issue("div_m7_2",  3'(DIV),    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        issue("rem_m7_2",  3'(REM),    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        issue("div_7_m2",  3'(DIV),    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
        issue("rem_7_m2",  3'(REM),    32'd7,          32'hFFFF_FFFE, 32'h0000_0001);
        issue("divu_100",  3'(DIVU),   32'd100,        32'd7,         32'd14);
        issue("remu_100",  3'(REMU),   32'd100,        32'd7,         32'd2);
        issue("divu_by0",  3'(DIVU),   32'd5,          32'd0,         32'hFFFF_FFFF);
        issue("remu_by0",  3'(REMU),   32'd5,          32'd0,         32'd5);
        issue("div_by0",   3'(DIV),    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF);
        issue("div_ovf",   3'(DIV),    C_MIN,          32'hFFFF_FFFF, C_MIN);
        issue("rem_ovf",   3'(REM),    C_MIN,          32'hFFFF_FFFF, 32'h0);
        issue("divu_big",  3'(DIVU),   C_MIN,          32'hFFFF_FFFF, 32'h0);

        // Non-M instructions never stall or complete.
        idle_instr(32'h0020_81B3, 3);
        idle_instr(mk(3'd0, 7'b0100000), 3);
        idle_instr(NOP_INSTR, 3);

        // Flush while BUSY at counter 10.
        bus.instr_ex    = mk(3'(MUL), 7'b0000001);
        bus.rs1_data_ex = 32'd5;
        bus.rs2_data_ex = 32'd9;
        for (int k = 0; k <= 10; k++) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
            step();
        end
        bus.flush = 1'b1;
        exp_stall = 1'b0;
        step();
        idle_instr(NOP_INSTR, 40);
        issue("mul_3_4",   3'(MUL),    32'd3,          32'd4,         32'd12);

        // Asynchronous reset in the middle of an operation.
        bus.instr_ex    = mk(3'(DIVU), 7'b0000001);
        bus.rs1_data_ex = 32'd1000;
        bus.rs2_data_ex = 32'd3;
        exp_stall       = 1'b1;
        exp_done        = 1'b0;
        repeat (6) step();
        rst          = 1'b1;
        bus.instr_ex = NOP_INSTR;
        exp_stall    = 1'b0;
        exp_result   = '0;
        #2;
        check("rst_async_result", bus.result_o, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        idle_instr(NOP_INSTR, 40);
        issue("remu_after_rst", 3'(REMU), 32'd1000, 32'd3, 32'd1);
        idle_instr(NOP_INSTR, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_muldiv_unit
`default_nettype wire
